// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the sequential divider.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/nonrestoring_step.sv
// One combinational non-restoring division iteration on the {P,A} pair.
// P is a (WIDTH+1)-bit two's-complement partial remainder, A holds the
// remaining dividend bits and collects quotient bits, D is the divisor
// magnitude.
module nonrestoring_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic signed [WIDTH:0] p_shift;
  logic signed [WIDTH:0] d_ext;
  logic signed [WIDTH:0] p_sum;

  // Shift {P,A} left, add or subtract D by the sign of P, append quotient bit
  always_comb begin
    p_shift = {p[WIDTH-1:0], a[WIDTH-1]};
    d_ext   = {1'b0, d};
    if (p[WIDTH]) begin
      p_sum = p_shift + d_ext;
    end else begin
      p_sum = p_shift - d_ext;
    end
    p_next = p_sum;
    a_next = {a[WIDTH-2:0], ~p_sum[WIDTH]};
  end

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle signed non-restoring divider producing {remainder, quotient}
// for the Z register pair. One quotient bit per clock, then a fix-up cycle
// that restores the remainder and applies the operand signs.
module seq_divider_32
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Magnitude of a two's-complement value; the most negative value maps to
  // itself, which is the correct unsigned magnitude in WIDTH bits.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Conditional two's-complement negation used for the sign fix-up.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? -x : x;
  endfunction

  div_state_t state;
  div_state_t next_state;

  logic [CNT_W-1:0]      cnt;
  logic signed [WIDTH:0] p;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      d;
  logic                  q_neg;
  logic                  r_neg;

  logic [WIDTH:0]        p_step;
  logic [WIDTH-1:0]      a_step;
  logic [WIDTH-1:0]      rem_mag;
  logic [WIDTH-1:0]      rem_fix;
  logic [WIDTH-1:0]      quo_fix;

  logic                  accept;
  logic                  div_zero_req;
  logic                  busy_d;
  logic                  done_d;

  nonrestoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p),
    .a      (a),
    .d      (d),
    .p_next (p_step),
    .a_next (a_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          next_state = FIX;
        end
      end
      FIX: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Control decode: next-cycle values of the registered handshake outputs
  always_comb begin
    accept       = start && ((state == IDLE) || (state == DONE));
    div_zero_req = accept && (divisor == '0);
    busy_d       = (next_state == CALC) || (next_state == FIX);
    done_d       = (state == FIX) || div_zero_req;
  end

  // Sign fix-up: restore a negative partial remainder, then apply signs
  always_comb begin
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    rem_fix = cond_neg(rem_mag, r_neg);
    quo_fix = cond_neg(a, q_neg);
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      p     <= '0;
      a     <= abs_val(dividend);
      d     <= abs_val(divisor);
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end else if (state == CALC) begin
      p <= p_step;
      a <= a_step;
    end
  end

  // Handshake outputs, iteration counter and result register
  always_ff @(posedge clk) begin
    if (clr) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
      cnt         <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        cnt <= '0;
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (div_zero_req) begin
        result      <= {dividend, {WIDTH{1'b1}}};
        div_by_zero <= 1'b1;
      end else if (state == FIX) begin
        result      <= {rem_fix, quo_fix};
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
